regfile_scoreboard: RTL and testbench

- Architectural register file plus in-flight-write scoreboard for the MIPS pipeline.
- It is the receiving end of the writeback interface: it consumes do_writeback1 / writeRegister1 / writeData1 from the WB stage and commits them.
- It serves two decode-stage read ports.
- It tracks outstanding writes per register so the hazard unit can stall consumers until data is committed.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_scoreboard_sb_counter.sv | 30 +++
 rtl/regfile_scoreboard.sv | 99 +++++++++
 tb/tb_regfile_scoreboard.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file / in-flight-write scoreboard.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int CNT_W    = 2;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [CNT_W-1:0]  sb_cnt_t;

  localparam reg_idx_t REG_ZERO  = '0;
  localparam sb_cnt_t  CNT_MAX_V = sb_cnt_t'(CNT_MAX);

endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// One per-register pending-write counter: saturating up/down with a
// zero-underflow indication (decrement requested while already at zero).
module sb_counter
  import regfile_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_underflow
);

  logic [CNT_W-1:0] r_count;

  assign o_count     = r_count;
  assign o_underflow = i_dec & ~i_inc & (r_count == '0);

  // Simultaneous inc and dec cancel; ends of the range hold rather than wrap.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_inc & ~i_dec & (r_count != CNT_MAX_V)) begin
      r_count <= r_count + sb_cnt_t'(1);
    end else if (i_dec & ~i_inc & (r_count != '0)) begin
      r_count <= r_count - sb_cnt_t'(1);
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with two combinational read ports and a
// per-register in-flight-write scoreboard. Macro REGFILE_BYPASS_EN enables
// same-cycle writeback-to-read forwarding for both data and pending.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              do_writeback1,
  input  logic [ADDR_W-1:0] writeRegister1,
  input  logic [DATA_W-1:0] writeData1,
  input  logic [ADDR_W-1:0] readRegisterA,
  input  logic [ADDR_W-1:0] readRegisterB,
  output logic [DATA_W-1:0] readDataA,
  output logic [DATA_W-1:0] readDataB,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              issue_ready,
  output logic              pendingA,
  output logic              pendingB,
  output logic              sb_underflow
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              r_sb_underflow;
  logic [CNT_W-1:0]  w_cnt  [NUM_REGS];
  logic [NUM_REGS-1:0] w_uf;
  logic              w_wb_en;
  logic              w_issue_fire;
  logic              w_dest_full;

  assign w_wb_en = do_writeback1 & (writeRegister1 != REG_ZERO);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wb_en) begin
      r_regs[writeRegister1] <= writeData1;
    end
  end

  // Issue handshake: an issue takes effect only on a cycle where
  // issue_valid && issue_ready; otherwise decode must hold issue_dest and
  // issue_valid stable. A writeback to the same register in that cycle frees
  // a slot, so a saturated counter still accepts the issue.
  assign w_dest_full  = (w_cnt[issue_dest] == CNT_MAX_V);
  assign issue_ready  = (issue_dest == REG_ZERO) | ~w_dest_full |
                        (w_wb_en & (writeRegister1 == issue_dest));
  assign w_issue_fire = issue_valid & issue_ready;

  assign w_cnt[0] = '0;
  assign w_uf[0]  = 1'b0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
    sb_counter u_cnt (
      .i_clk       (CLK),
      .i_reset     (RESET),
      .i_inc       (w_issue_fire & (issue_dest == reg_idx_t'(g))),
      .i_dec       (w_wb_en & (writeRegister1 == reg_idx_t'(g))),
      .o_count     (w_cnt[g]),
      .o_underflow (w_uf[g])
    );
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sb_underflow <= 1'b0;
    end else if (|w_uf) begin
      r_sb_underflow <= 1'b1;
    end
  end

  assign sb_underflow = r_sb_underflow;

`ifdef REGFILE_BYPASS_EN
  logic w_fwd_a;
  logic w_fwd_b;

  assign w_fwd_a = w_wb_en & (writeRegister1 == readRegisterA);
  assign w_fwd_b = w_wb_en & (writeRegister1 == readRegisterB);

  assign readDataA = (readRegisterA == REG_ZERO) ? '0 :
                     w_fwd_a ? writeData1 : r_regs[readRegisterA];
  assign readDataB = (readRegisterB == REG_ZERO) ? '0 :
                     w_fwd_b ? writeData1 : r_regs[readRegisterB];

  // A matching writeback retires one outstanding producer this cycle.
  assign pendingA = (w_cnt[readRegisterA] != '0) &
                    ~(w_fwd_a & (w_cnt[readRegisterA] == sb_cnt_t'(1)));
  assign pendingB = (w_cnt[readRegisterB] != '0) &
                    ~(w_fwd_b & (w_cnt[readRegisterB] == sb_cnt_t'(1)));
`else
  assign readDataA = (readRegisterA == REG_ZERO) ? '0 : r_regs[readRegisterA];
  assign readDataB = (readRegisterB == REG_ZERO) ? '0 : r_regs[readRegisterB];
  assign pendingA  = (w_cnt[readRegisterA] != '0);
  assign pendingB  = (w_cnt[readRegisterB] != '0);
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: reference model of data,
// counters and underflow flag, with read expectations queued and popped.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  logic              CLK;
  logic              RESET;
  logic              do_writeback1;
  logic [ADDR_W-1:0] writeRegister1;
  logic [DATA_W-1:0] writeData1;
  logic [ADDR_W-1:0] readRegisterA;
  logic [ADDR_W-1:0] readRegisterB;
  logic [DATA_W-1:0] readDataA;
  logic [DATA_W-1:0] readDataB;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_dest;
  logic              issue_ready;
  logic              pendingA;
  logic              pendingB;
  logic              sb_underflow;

  regfile_scoreboard dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .do_writeback1  (do_writeback1),
    .writeRegister1 (writeRegister1),
    .writeData1     (writeData1),
    .readRegisterA  (readRegisterA),
    .readRegisterB  (readRegisterB),
    .readDataA      (readDataA),
    .readDataB      (readDataB),
    .issue_valid    (issue_valid),
    .issue_dest     (issue_dest),
    .issue_ready    (issue_ready),
    .pendingA       (pendingA),
    .pendingB       (pendingB),
    .sb_underflow   (sb_underflow)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] model_regs[NUM_REGS];
  int                model_cnt[NUM_REGS];
  logic              model_uf;

  task automatic check_val(input string tag, input logic [DATA_W-1:0] obs,
                           input logic [DATA_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_REGS; i++) begin
      model_regs[i] = '0;
      model_cnt[i]  = 0;
    end
    model_uf = 1'b0;
  endtask

  // driver tasks
  task automatic do_reset();
    RESET = 1'b1;
    cycle();
    cycle();
    RESET = 1'b0;
    model_clear();
  endtask

  task automatic issue(input int idx);
    issue_valid = 1'b1;
    issue_dest  = reg_idx_t'(idx);
    cycle();
    issue_valid = 1'b0;
    if (idx != 0 && model_cnt[idx] < CNT_MAX) model_cnt[idx]++;
  endtask

  task automatic writeback(input int idx, input logic [DATA_W-1:0] data);
    do_writeback1  = 1'b1;
    writeRegister1 = reg_idx_t'(idx);
    writeData1     = data;
    cycle();
    do_writeback1 = 1'b0;
    if (idx != 0) begin
      model_regs[idx] = data;
      if (model_cnt[idx] == 0) model_uf = 1'b1;
      else model_cnt[idx]--;
    end
  endtask

  task automatic read_a(input string tag, input int idx);
    readRegisterA = reg_idx_t'(idx);
    exp_q.push_back(model_regs[idx]);
    #1;
    check_val(tag, readDataA, exp_q.pop_front());
    check_val({tag, "_pend"}, DATA_W'(pendingA), DATA_W'(model_cnt[idx] != 0));
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    int r;

    RESET = 1'b0; do_writeback1 = 1'b0; writeRegister1 = '0; writeData1 = '0;
    readRegisterA = '0; readRegisterB = '0; issue_valid = 1'b0; issue_dest = '0;
    model_clear();
    do_reset();

    // reset state
    readRegisterB = '0;
    issue_dest    = reg_idx_t'(5);
    read_a("rst_a5", 5);
    check_val("rst_b0", readDataB, '0);
    check_val("rst_pendb", DATA_W'(pendingB), '0);
    check_val("rst_ready", DATA_W'(issue_ready), DATA_W'(1));
    check_val("rst_uf", DATA_W'(sb_underflow), '0);

    // basic commit, and register 0 discards writes
    issue(7);
    read_a("r7_pend", 7);
    writeback(7, 32'hDEADBEEF);
    read_a("r7_data", 7);
    writeback(0, 32'h0000_1234);
    read_a("r0_data", 0);
    readRegisterA = reg_idx_t'(7);
    readRegisterB = reg_idx_t'(7);
    #1;
    check_val("same_ab", readDataB, readDataA);
    check_val("same_b7", readDataB, 32'hDEADBEEF);

    // same-cycle writeback with read of the same register
    issue(9);
    readRegisterA  = reg_idx_t'(9);
    do_writeback1  = 1'b1;
    writeRegister1 = reg_idx_t'(9);
    writeData1     = 32'hCAFE0001;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'hCAFE0001);
    #1;
    check_val("byp_data", readDataA, exp_q.pop_front());
    check_val("byp_pend", DATA_W'(pendingA), '0);
`else
    exp_q.push_back(model_regs[9]);
    #1;
    check_val("nobyp_data", readDataA, exp_q.pop_front());
    check_val("nobyp_pend", DATA_W'(pendingA), DATA_W'(1));
`endif
    cycle();
    do_writeback1 = 1'b0;
    model_regs[9] = 32'hCAFE0001;
    model_cnt[9]  = 0;
    read_a("r9_next", 9);

    // saturation of the r3 counter
    issue(3); issue(3); issue(3);
    issue_valid = 1'b1;
    issue_dest  = reg_idx_t'(3);
    #1;
    check_val("sat_ready", DATA_W'(issue_ready), '0);
    cycle();
    issue_valid = 1'b0;
    read_a("sat_r3", 3);
    do_writeback1 = 1'b1; writeRegister1 = reg_idx_t'(3); writeData1 = 32'h0000_0033;
    issue_valid = 1'b1; issue_dest = reg_idx_t'(3);
    #1;
    check_val("sat_wb_ready", DATA_W'(issue_ready), DATA_W'(1));
    cycle();
    do_writeback1 = 1'b0; issue_valid = 1'b0;
    model_regs[3] = 32'h0000_0033;
    issue_valid = 1'b1;
    #1;
    check_val("sat_still3", DATA_W'(issue_ready), '0);
    cycle();
    issue_valid = 1'b0;
    writeback(3, 32'h0000_0034); read_a("r3_wb1", 3);
    writeback(3, 32'h0000_0035); read_a("r3_wb2", 3);
    writeback(3, 32'h0000_0036); read_a("r3_wb3", 3);

    // simultaneous issue and writeback on r4 with counter 1
    issue(4);
    do_writeback1 = 1'b1; writeRegister1 = reg_idx_t'(4); writeData1 = 32'h0000_0044;
    issue_valid = 1'b1; issue_dest = reg_idx_t'(4);
    cycle();
    do_writeback1 = 1'b0; issue_valid = 1'b0;
    model_regs[4] = 32'h0000_0044;
    read_a("r4_both", 4);
    writeback(4, 32'h0000_0045);
    read_a("r4_done", 4);
    check_val("no_uf", DATA_W'(sb_underflow), '0);

    // underflow is sticky and data is still committed
    writeback(12, 32'h55AA_1234);
    check_val("uf_set", DATA_W'(sb_underflow), DATA_W'(model_uf));
    read_a("r12_data", 12);
    cycle();
    check_val("uf_sticky", DATA_W'(sb_underflow), DATA_W'(1));

    // random issue/writeback pairs
    for (int i = 0; i < 8; i++) begin
      r = $urandom_range(1, NUM_REGS - 1);
      d = $urandom;
      issue(r);
      read_a($sformatf("rnd%0d_pend", i), r);
      writeback(r, d);
      read_a($sformatf("rnd%0d_data", i), r);
    end

    // reset mid-stream drops a simultaneous writeback and issue
    writeback(7, 32'h0BAD_F00D);
    issue(20); issue(20);
    RESET = 1'b1;
    do_writeback1 = 1'b1; writeRegister1 = reg_idx_t'(21); writeData1 = 32'h2121_2121;
    issue_valid = 1'b1; issue_dest = reg_idx_t'(22);
    cycle();
    RESET = 1'b0; do_writeback1 = 1'b0; issue_valid = 1'b0;
    model_clear();
    read_a("mrst_r20", 20);
    read_a("mrst_r21", 21);
    read_a("mrst_r22", 22);
    read_a("mrst_r7", 7);
    check_val("mrst_uf", DATA_W'(sb_underflow), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
